// File: rtl/ga_pkg.sv
// rtl/ga_pkg.sv - shared types and default constants for the GA coordinate receiver
package ga_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  typedef enum logic {
    SLOT_X,
    SLOT_Y
  } pair_slot_t;

  localparam int GA_SIZE      = 8;
  localparam int GA_MAX_COORD = 180;

endpackage

// File: rtl/ga_bit_sync.sv
// rtl/ga_bit_sync.sv - two-flop synchronizer (resets to 1) with falling-edge pulse
module ga_bit_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_din,
  output logic o_sync,
  output logic o_fall
);

  logic       r_meta;
  logic       r_sync;
  logic [1:0] r_fill;
  logic       r_prev_hi;

  // r_prev_hi only trusts samples taken after reset, so a line held low
  // through reset never looks like a fresh start edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta    <= 1'b1;
      r_sync    <= 1'b1;
      r_fill    <= 2'b00;
      r_prev_hi <= 1'b0;
    end else begin
      r_meta    <= i_din;
      r_sync    <= r_meta;
      r_fill    <= {r_fill[0], 1'b1};
      r_prev_hi <= r_fill[1] & r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_fall = r_prev_hi & ~r_sync;

endmodule

// File: rtl/ga_coord_deserializer.sv
// rtl/ga_coord_deserializer.sv - serial frame receiver pairing bytes into (X, Y) coordinates
// Optional even-parity bit per frame when GA_RX_PARITY_EN is defined.
module ga_coord_deserializer
  import ga_pkg::*;
#(
  parameter int SIZE      = GA_SIZE,
  parameter int BIT_CLKS  = 16,
  parameter int MAX_COORD = GA_MAX_COORD
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            DIN,
  output logic [SIZE-1:0] X_OUT,
  output logic [SIZE-1:0] Y_OUT,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic            FRAME_ERR,
  output logic            RANGE_ERR,
  output logic            OVERRUN,
  input  logic            ERR_CLR
);

  localparam int BCW = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;
  localparam int DCW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [BCW-1:0]  C_BIT_LAST  = BCW'(BIT_CLKS - 1);
  localparam logic [BCW-1:0]  C_BIT_HALF  = BCW'(BIT_CLKS / 2);
  localparam logic [DCW-1:0]  C_DATA_LAST = DCW'(SIZE - 1);
  localparam logic [SIZE-1:0] C_MAX       = SIZE'(MAX_COORD);

  logic            w_sync;
  logic            w_fall;
  logic            w_mid;
  logic            w_par_bad;
  rx_state_t       r_state;
  rx_state_t       w_state_nxt;
  logic            w_load_cnt;
  logic            w_shift_en;
  logic            w_frame_bad;
  logic            w_byte_done;
  logic            w_range_bad;
  logic            w_accept;
  logic            w_pair;
  logic            w_load;
  logic            w_over;

  logic [BCW-1:0]  r_bit_cnt;
  logic [DCW-1:0]  r_data_cnt;
  logic [SIZE-1:0] r_shift;
  logic [SIZE-1:0] r_x_tmp;
  pair_slot_t      r_slot;
  logic [SIZE-1:0] r_x_out;
  logic [SIZE-1:0] r_y_out;
  logic            r_valid;
  logic            r_frame_err;
  logic            r_range_err;
  logic            r_overrun;

  ga_bit_sync u_sync (
    .i_clk   (CLK),
    .i_reset (RESET),
    .i_din   (DIN),
    .o_sync  (w_sync),
    .o_fall  (w_fall)
  );

  assign w_mid = (r_bit_cnt == C_BIT_LAST);

`ifdef GA_RX_PARITY_EN
  logic r_par_bad;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_par_bad <= 1'b0;
    end else if (r_state == PARITY && w_mid) begin
      r_par_bad <= w_sync ^ (^r_shift);
    end
  end

  assign w_par_bad = r_par_bad;
`else
  assign w_par_bad = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_cnt  = 1'b0;
    w_shift_en  = 1'b0;
    w_frame_bad = 1'b0;
    w_byte_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_nxt = START;
          w_load_cnt  = 1'b1;
        end
      end
      START: begin
        if (w_mid) w_state_nxt = w_sync ? IDLE : DATA;
      end
      DATA: begin
        if (w_mid) begin
          w_shift_en = 1'b1;
`ifdef GA_RX_PARITY_EN
          if (r_data_cnt == C_DATA_LAST) w_state_nxt = PARITY;
`else
          if (r_data_cnt == C_DATA_LAST) w_state_nxt = STOP;
`endif
        end
      end
`ifdef GA_RX_PARITY_EN
      PARITY: begin
        if (w_mid) w_state_nxt = STOP;
      end
`endif
      STOP: begin
        // Returning to IDLE at mid-stop lets a start edge in the back half be caught.
        if (w_mid) begin
          w_state_nxt = IDLE;
          if (!w_sync || w_par_bad) w_frame_bad = 1'b1;
          else                      w_byte_done = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_range_bad = (r_shift > C_MAX);
  assign w_accept    = w_byte_done & ~w_range_bad;
  assign w_pair      = w_accept & (r_slot == SLOT_Y);
  assign w_load      = w_pair & (~r_valid | OUT_READY);
  assign w_over      = w_pair & ~w_load;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_bit_cnt   <= '0;
      r_data_cnt  <= '0;
      r_shift     <= '0;
      r_x_tmp     <= '0;
      r_slot      <= SLOT_X;
      r_x_out     <= '0;
      r_y_out     <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_range_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_load_cnt)             r_bit_cnt <= C_BIT_HALF;
      else if (r_state != IDLE)   r_bit_cnt <= w_mid ? '0 : r_bit_cnt + 1'b1;

      if (w_load_cnt)      r_data_cnt <= '0;
      else if (w_shift_en) r_data_cnt <= (r_data_cnt == C_DATA_LAST) ? '0 : r_data_cnt + 1'b1;

      if (w_shift_en) r_shift <= {w_sync, r_shift[SIZE-1:1]};

      if (w_frame_bad || (w_byte_done && w_range_bad)) begin
        r_slot <= SLOT_X;
      end else if (w_accept) begin
        if (r_slot == SLOT_X) begin
          r_x_tmp <= r_shift;
          r_slot  <= SLOT_Y;
        end else begin
          r_slot  <= SLOT_X;
        end
      end

      if (w_load) begin
        r_x_out <= r_x_tmp;
        r_y_out <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && OUT_READY) begin
        r_valid <= 1'b0;
      end

      r_frame_err <= w_frame_bad;
      r_range_err <= w_byte_done & w_range_bad;

      if (w_over)       r_overrun <= 1'b1;
      else if (ERR_CLR) r_overrun <= 1'b0;
    end
  end

  assign X_OUT     = r_x_out;
  assign Y_OUT     = r_y_out;
  assign OUT_VALID = r_valid;
  assign FRAME_ERR = r_frame_err;
  assign RANGE_ERR = r_range_err;
  assign OVERRUN   = r_overrun;

endmodule
